// File: rtl/ps2_byte_rx_pkg.sv
// Shared types and frame constants for the PS/2 byte receiver.
package hack_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

endpackage

// File: rtl/ps2_byte_rx_if.sv
// Byte output channel of the PS/2 receiver: one-entry valid/ready plus
// single-cycle fault pulses.
interface ps2_byte_rx_if;
  import hack_ps2_pkg::*;

  logic [PS2_DATA_BITS-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     frame_err;
  logic                     overrun;

  modport master (
    output out_data, out_valid, frame_err, overrun,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, frame_err, overrun,
    output out_ready
  );
endinterface

// File: rtl/ps2_byte_rx_sync_edge.sv
// Pin synchronizer with a registered falling-edge detect. The level output
// is the delayed synced value, aligned with fe, so two instances of this
// module give clock and data paths of equal depth.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   fe_q;

  // Synchronizer chain, one-cycle history and registered falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fe_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
      fe_q   <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign level = prev_q;
  assign fe    = fe_q;

endmodule

// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host frame receiver: deserializes 11-bit frames into bytes,
// holds each byte in a one-entry valid/ready register, and pulses frame_err
// or overrun on faults.
module ps2_byte_rx
  import hack_ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_byte_rx_if.master ob
);

  localparam int                 TW       = $clog2(TIMEOUT_CYCLES);
  localparam int                 BW       = $clog2(PS2_DATA_BITS);
  localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0]      BIT_LAST = BW'(PS2_DATA_BITS - 1);

  logic clk_fe;
  logic clk_lvl_unused;
  logic data_lvl;
  logic data_fe_unused;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2_clk),
    .level (clk_lvl_unused),
    .fe    (clk_fe)
  );

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2_data),
    .level (data_lvl),
    .fe    (data_fe_unused)
  );

  ps2_state_e               state_q, state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     par_ok_q, par_ok_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     good_stop;
  logic                     bad_frame;

  logic [PS2_DATA_BITS-1:0] out_data_q;
  logic                     out_valid_q;
  logic                     frame_err_q;
  logic                     overrun_q;

  // Frame state, bit counter, shift register, parity flag and idle timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_ok_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_ok_q  <= par_ok_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state: every frame step advances on a ps2_clk fall; the idle timer
  // is the only way out of a frame without one.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_ok_d  = par_ok_q;
    tmo_d     = tmo_q;
    good_stop = 1'b0;
    bad_frame = 1'b0;

    if (state_q == ST_IDLE || clk_fe) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      // Abandon the partial frame; the next start bit begins clean.
      tmo_d     = '0;
      state_d   = ST_IDLE;
      shreg_d   = '0;
      bad_frame = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (clk_fe) begin
      case (state_q)
        ST_IDLE: begin
          // A high data line here is a glitch, not a start bit; ignore it.
          if (data_lvl == START_BIT) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d = {data_lvl, shreg_q[PS2_DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) state_d = ST_PARITY;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end
        ST_PARITY: begin
          par_ok_d = ^{shreg_q, data_lvl};
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_lvl == STOP_BIT && par_ok_q) good_stop = 1'b1;
          else                                  bad_frame = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Holding register: a delivery wins over a same-cycle accept, and a full
  // register that is not being drained drops the new byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= bad_frame;
      overrun_q   <= 1'b0;
      if (good_stop) begin
        if (!out_valid_q || ob.out_ready) begin
          out_data_q  <= shreg_q;
          out_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (out_valid_q && ob.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign ob.out_data  = out_data_q;
  assign ob.out_valid = out_valid_q;
  assign ob.frame_err = frame_err_q;
  assign ob.overrun   = overrun_q;

endmodule
